snake_head_stepper: RTL and testbench
=====================================

// Module: snake_head_stepper
// PURPOSE
//   Upstream stage of the snake body shift registers. Turns KEY presses into a
//   latched heading and blocks 180-degree reversals. On each step request from the
//   draw/erase FSM it computes the next head (x,y) and presents it as the new
//   data_in of the X/Y body shift registers, with a one-cycle shift enable.
//   Also owns the animation-rate divider that produces the frame sync tick.
// PARAMETERS
//   XSCREEN  160  screen width in pixels
//   YSCREEN  120  screen height in pixels
//   STEP     10   head displacement per step (= segment size XDIM/YDIM)
//   X0       80   head x after reset
//   Y0       30   head y after reset
//   K        20   divider width; tick every 2^K clocks (use 2 in simulation)
// PORTS
//   clk        in   1  system clock (CLOCK_50)
//   reset      in   1  asynchronous, active-high; clears all state
//   key_n      in   4  raw active-low keys: [0]=right [1]=down [2]=up [3]=left
//   run        in   1  1 = game running; 0 = hold in IDLE
//   step_req   in   1  one-cycle pulse from draw FSM: "advance head now"
//   head_x     out  8  committed head x (upper-left pixel of head segment)
//   head_y     out  7  committed head y
//   dir        out  2  committed heading: 0=right 1=down 2=up 3=left
//   step_valid out  1  one-cycle pulse: head_x/head_y hold the new head; drives Eshift
//   tick       out  1  one-cycle pulse when divider wraps to 0 (frame sync)
//   wall_hit   out  1  sticky: head would have left the screen (no-wrap build)
// BEHAVIOUR
//   Reset values: head_x=X0, head_y=Y0, dir=0 (right), pending=0, step_valid=0,
//     tick=0, wall_hit=0, divider=0, FSM=IDLE, key synchroniser flops=4'hF.
//   Keys: two-flop synchroniser per bit, then priority right>down>up>left among
//     keys low. pending_dir loads the winner only if it is not the opposite of the
//     committed dir (0<->3, 1<->2); otherwise pending_dir is held. No key: held.
//   Divider: K-bit counter increments every clock while run=1 and holds at 0 when
//     run=0. tick=1 for the single cycle in which the counter reads 0 and run=1.
//   FSM: IDLE  -> READY when run=1.
//        READY -> STEP on step_req; -> IDLE if run=0 (run=0 has priority).
//        STEP  -> READY after 1 cycle (commit cycle, see below); -> DEAD on wall.
//        DEAD  -> stays until reset; step_valid never asserted.
//   Commit (STEP state): dir<=pending_dir. head moves STEP px in pending_dir
//     (right:+x, left:-x, down:+y, up:-y). Registered step_valid=1 in the next cycle
//     (READY), so step_valid rises exactly 2 clocks after step_req; head regs are
//     already updated when step_valid is seen.
//   step_req outside READY is ignored (no queuing).
//   Key change in the same cycle as step_req: the pending_dir registered before
//     that edge is used; the new key affects the next step only.
//   Bounds: valid head x in [0, XSCREEN-STEP]; valid y in [0, YSCREEN-STEP].
//     Compare in 9-bit/8-bit signed-safe widths: right edge if x+STEP>XSCREEN-STEP;
//     left edge if x<STEP (same for y).
//   Reset asserted mid-step: everything returns to reset values immediately and
//     no step_valid is emitted.
// CONFIGURATION
//   SNAKE_WRAP_EN defined: moves past an edge wrap (right->x=0,
//     left->x=XSCREEN-STEP, down->y=0, up->y=YSCREEN-STEP). wall_hit is tied to 0.
//     DEAD is unreachable.
//   SNAKE_WRAP_EN undefined: an out-of-bounds move leaves head unchanged, sets
//     wall_hit=1, suppresses step_valid, and enters DEAD.
// TESTING
//   reset, run=1, step_req pulse -> 2 clks later step_valid=1, head=(90,30), dir=0
//   key_n=4'b0111 (left) while dir=right, step -> reversal rejected, head=(100,30)
//   key_n=4'b1101 (down), step, then key_n=4'b1011 (up), step -> y 30->40, then
//     up ignored, y=50
//   head=(150,30) dir=right, step: WRAP_EN -> x=0; else wall_hit=1, x=150, no
//     step_valid, later step_req ignored
//   K=2, run=1 -> tick every 4 clks; run=0 -> tick=0 and FSM in IDLE
//   reset pulse between step_req and step_valid -> head=(80,30), no step_valid

Source files
------------

// File: rtl/snake_head_stepper.sv
// ---------------------------------------------------------------------------
// snake_head_stepper
//
// Front end of the snake body shift registers. Debounce-free key handling
// (two-flop synchroniser + fixed priority) latches a pending heading, refusing
// any 180-degree reversal against the committed heading. When the draw/erase
// FSM asks for a step, the head advances STEP pixels and the new position is
// offered to the X/Y body shift registers with a one-cycle step_valid.
// The block also owns the animation-rate divider that produces `tick`.
//
// Build option:
//   SNAKE_WRAP_EN  defined   -> head wraps at screen edges, wall_hit tied 0
//                  undefined -> an off-screen move freezes the head, raises
//                               wall_hit and parks the FSM in DEAD
//
// Ports:
//   clk        system clock (CLOCK_50)
//   reset      asynchronous, active-high; clears all state
//   key_n      raw active-low keys: [0]=right [1]=down [2]=up [3]=left
//   run        1 = game running, 0 = hold in IDLE
//   step_req   one-cycle pulse from draw FSM: advance the head
//   head_x     committed head x (upper-left pixel of head segment)
//   head_y     committed head y
//   dir        committed heading: 0=right 1=down 2=up 3=left
//   step_valid one-cycle pulse, head_x/head_y already hold the new head
//   tick       one-cycle frame-sync pulse when the divider reads 0
//   wall_hit   sticky: a move would have left the screen
// ---------------------------------------------------------------------------
module snake_head_stepper #(
    parameter int XSCREEN = 160,
    parameter int YSCREEN = 120,
    parameter int STEP    = 10,
    parameter int X0      = 80,
    parameter int Y0      = 30,
    parameter int K       = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_n,
    input  logic       run,
    input  logic       step_req,
    output logic [7:0] head_x,
    output logic [6:0] head_y,
    output logic [1:0] dir,
    output logic       step_valid,
    output logic       tick,
    output logic       wall_hit
);

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    // Edge tests are done one bit wider than the coordinate so x+STEP
    // cannot overflow before the comparison.
    localparam logic [8:0] X_MAX9  = 9'(XSCREEN - STEP);
    localparam logic [8:0] STEP9   = 9'(STEP);
    localparam logic [7:0] Y_MAX8  = 8'(YSCREEN - STEP);
    localparam logic [7:0] STEP8   = 8'(STEP);
    localparam logic [7:0] X_STEP  = 8'(STEP);
    localparam logic [6:0] Y_STEP  = 7'(STEP);
    localparam logic [7:0] X_WRAPL = 8'(XSCREEN - STEP);
    localparam logic [6:0] Y_WRAPU = 7'(YSCREEN - STEP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READY = 2'd1,
        S_STEP  = 2'd2,
        S_DEAD  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // -----------------------------------------------------------------------
    // Key synchroniser and heading selection
    // -----------------------------------------------------------------------
    logic [3:0] key_meta, key_sync;
    logic       key_hit;
    logic [1:0] key_dir;
    logic [1:0] pending_dir;
    logic       reversal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_meta <= 4'hF;
            key_sync <= 4'hF;
        end else begin
            key_meta <= key_n;
            key_sync <= key_meta;
        end
    end

    // Lowest pressed bit wins (right > down > up > left); the direction code
    // is simply the key index.
    always_comb begin
        key_hit = 1'b0;
        key_dir = DIR_RIGHT;
        for (int i = 3; i >= 0; i--) begin
            if (!key_sync[i]) begin
                key_hit = 1'b1;
                key_dir = 2'(i);
            end
        end
    end

    // Opposite headings are bitwise complements (0<->3, 1<->2).
    assign reversal = (key_dir == ~dir);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pending_dir <= DIR_RIGHT;
        else if (key_hit && !reversal)
            pending_dir <= key_dir;
    end

    // -----------------------------------------------------------------------
    // Animation-rate divider
    // -----------------------------------------------------------------------
    logic [K-1:0] div_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            div_cnt <= '0;
        else if (run)
            div_cnt <= div_cnt + 1'b1;
        else
            div_cnt <= '0;
    end

    assign tick = run & ~reset & (div_cnt == '0);

    // -----------------------------------------------------------------------
    // Next-head computation for the latched step direction
    // -----------------------------------------------------------------------
    logic [1:0] step_dir;    // pending_dir captured on the accepted step_req
    logic [8:0] x9;
    logic [7:0] y8;
    logic       edge_hit;
    logic [7:0] nxt_x;
    logic [6:0] nxt_y;
    logic       blocked;

    assign x9 = {1'b0, head_x};
    assign y8 = {1'b0, head_y};

    always_comb begin
        nxt_x    = head_x;
        nxt_y    = head_y;
        edge_hit = 1'b0;
        case (step_dir)
            DIR_RIGHT: begin
                edge_hit = (x9 + STEP9) > X_MAX9;
                nxt_x    = edge_hit ? 8'd0 : head_x + X_STEP;
            end
            DIR_LEFT: begin
                edge_hit = x9 < STEP9;
                nxt_x    = edge_hit ? X_WRAPL : head_x - X_STEP;
            end
            DIR_DOWN: begin
                edge_hit = (y8 + STEP8) > Y_MAX8;
                nxt_y    = edge_hit ? 7'd0 : head_y + Y_STEP;
            end
            default: begin  // DIR_UP
                edge_hit = y8 < STEP8;
                nxt_y    = edge_hit ? Y_WRAPU : head_y - Y_STEP;
            end
        endcase
    end

`ifdef SNAKE_WRAP_EN
    assign blocked = 1'b0;
`else
    assign blocked = edge_hit;
`endif

    // -----------------------------------------------------------------------
    // Step FSM: state register / next state / outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (run) state_nxt = S_READY;
            S_READY: begin
                if (!run)
                    state_nxt = S_IDLE;
                else if (step_req)
                    state_nxt = S_STEP;
            end
            S_STEP:  state_nxt = blocked ? S_DEAD : S_READY;
            default: state_nxt = S_DEAD;
        endcase
    end

    logic accept_req;   // step_req taken this cycle
    logic commit_ok;    // STEP cycle with an in-bounds (or wrapped) move
    logic commit_wall;  // STEP cycle that ran into an edge

    always_comb begin
        accept_req  = 1'b0;
        commit_ok   = 1'b0;
        commit_wall = 1'b0;
        case (state)
            S_READY: accept_req  = run & step_req;
            S_STEP: begin
                commit_ok   = ~blocked;
                commit_wall = blocked;
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Committed head / heading registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_x     <= 8'(X0);
            head_y     <= 7'(Y0);
            dir        <= DIR_RIGHT;
            step_dir   <= DIR_RIGHT;
            step_valid <= 1'b0;
        end else begin
            // Key changes landing in the request cycle only reach pending_dir
            // after this capture, so they apply to the following step.
            if (accept_req)
                step_dir <= pending_dir;
            if (commit_ok || commit_wall)
                dir <= step_dir;
            if (commit_ok) begin
                head_x <= nxt_x;
                head_y <= nxt_y;
            end
            step_valid <= commit_ok;
        end
    end

`ifdef SNAKE_WRAP_EN
    assign wall_hit = 1'b0;
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wall_hit <= 1'b0;
        else if (commit_wall)
            wall_hit <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_snake_head_stepper.sv
module tb_snake_head_stepper;

    localparam int XS = 160;
    localparam int YS = 120;
    localparam int ST = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] key_n = 4'hF;
    logic       run = 1'b0;
    logic       step_req = 1'b0;
    logic [7:0] head_x;
    logic [6:0] head_y;
    logic [1:0] dir;
    logic       step_valid, tick, wall_hit;

    int errors = 0;
    int checks = 0;

    snake_head_stepper #(.XSCREEN(XS), .YSCREEN(YS), .STEP(ST), .X0(80), .Y0(30), .K(2)) dut (
        .clk(clk), .reset(reset), .key_n(key_n), .run(run), .step_req(step_req),
        .head_x(head_x), .head_y(head_y), .dir(dir),
        .step_valid(step_valid), .tick(tick), .wall_hit(wall_hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks where the head must be, in whole-pixel integers, plus a coarse
    // "phase" of the step handshake. Inputs are stable at negedge and are the
    // values the DUT will sample at the next rising edge.
    int m_x, m_y, m_dir, m_pend, m_sdir, m_phase, m_sv, m_wall, m_streak;
    logic [3:0] m_k1, m_k2;   // key samples one and two edges old

    task automatic model_reset();
        m_x = 80; m_y = 30; m_dir = 0; m_pend = 0; m_sdir = 0;
        m_phase = 0; m_sv = 0; m_wall = 0; m_streak = 0;
        m_k1 = 4'hF; m_k2 = 4'hF;
    endtask

    task automatic model_advance();
        int win, npend, nx, ny;
        bit out;
        win = -1;
        for (int i = 0; i < 4; i++)
            if (!m_k2[i] && win < 0) win = i;
        npend = (win >= 0 && win != 3 - m_dir) ? win : m_pend;
        m_sv = 0;
        case (m_phase)
            0: if (run) m_phase = 1;
            1: begin
                if (!run) m_phase = 0;
                else if (step_req) begin m_phase = 2; m_sdir = m_pend; end
            end
            2: begin
                nx = m_x + ((m_sdir == 0) ? ST : (m_sdir == 3) ? -ST : 0);
                ny = m_y + ((m_sdir == 1) ? ST : (m_sdir == 2) ? -ST : 0);
                out = (nx < 0) || (nx > XS - ST) || (ny < 0) || (ny > YS - ST);
                m_dir = m_sdir;
`ifdef SNAKE_WRAP_EN
                m_x = (nx + XS) % XS; m_y = (ny + YS) % YS; m_sv = 1; m_phase = 1;
`else
                if (out) begin m_wall = 1; m_phase = 3; end
                else begin m_x = nx; m_y = ny; m_sv = 1; m_phase = 1; end
`endif
            end
            default: ;
        endcase
        m_pend = npend;
        m_streak = run ? m_streak + 1 : 0;
        m_k2 = m_k1;
        m_k1 = key_n;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (reset) model_reset();
            chk("cyc_head_x", int'(head_x), m_x);
            chk("cyc_head_y", int'(head_y), m_y);
            chk("cyc_dir", int'(dir), m_dir);
            chk("cyc_step_valid", int'(step_valid), m_sv);
            chk("cyc_wall_hit", int'(wall_hit), m_wall);
            chk("cyc_tick", int'(tick), int'(run && !reset && (m_streak % 4 == 0)));
            if (!reset) model_advance();
        end
    end

    // ---------------- stimulus ----------------
    task automatic clks(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_key(input logic [3:0] k);
        key_n = k;
        clks(3);
    endtask

    // Pulse step_req for one clock; returns just after the commit edge.
    task automatic do_step();
        step_req = 1'b1;
        clks(1);
        step_req = 1'b0;
        chk("sv_not_early", int'(step_valid), 0);
        clks(1);
    endtask

    int tcount;

    initial begin
        clks(3);
        chk("rst_x", int'(head_x), 80);
        chk("rst_y", int'(head_y), 30);
        chk("rst_dir", int'(dir), 0);
        chk("rst_sv", int'(step_valid), 0);
        chk("rst_wall", int'(wall_hit), 0);
        chk("rst_tick", int'(tick), 0);
        reset = 1'b0;
        clks(1);
        run = 1'b1;
        clks(2);

        do_step();
        chk("first_sv", int'(step_valid), 1);
        chk("first_x", int'(head_x), 90);
        chk("first_y", int'(head_y), 30);
        chk("first_dir", int'(dir), 0);
        clks(1);
        chk("sv_one_cycle", int'(step_valid), 0);

        set_key(4'b0111);
        do_step();
        chk("rev_left_x", int'(head_x), 100);
        chk("rev_left_dir", int'(dir), 0);

        set_key(4'b1101);
        do_step();
        chk("down_y", int'(head_y), 40);
        chk("down_dir", int'(dir), 1);
        set_key(4'b1011);
        do_step();
        chk("rev_up_y", int'(head_y), 50);
        chk("rev_up_dir", int'(dir), 1);

        set_key(4'b1110);
        repeat (5) do_step();
        key_n = 4'hF;
        chk("edge_x", int'(head_x), 150);
        chk("edge_dir", int'(dir), 0);
        do_step();
`ifdef SNAKE_WRAP_EN
        chk("wrap_x", int'(head_x), 0);
        chk("wrap_sv", int'(step_valid), 1);
        chk("wrap_wall", int'(wall_hit), 0);
`else
        chk("wall_x", int'(head_x), 150);
        chk("wall_sv", int'(step_valid), 0);
        chk("wall_hit", int'(wall_hit), 1);
        clks(2);
        do_step();
        chk("dead_x", int'(head_x), 150);
        chk("dead_sv", int'(step_valid), 0);
        clks(1);
        chk("dead_sv2", int'(step_valid), 0);
`endif

        // Divider and IDLE hold
        reset = 1'b1;
        run = 1'b0;
        clks(2);
        reset = 1'b0;
        clks(3);
        chk("idle_tick", int'(tick), 0);
        run = 1'b1;
        tcount = 0;
        repeat (16) begin clks(1); tcount += int'(tick); end
        chk("tick_per_16", tcount, 4);
        run = 1'b0;
        clks(2);
        chk("run0_tick", int'(tick), 0);
        do_step();
        clks(1);
        chk("idle_x", int'(head_x), 80);
        chk("idle_sv", int'(step_valid), 0);

        // Key change in the step_req cycle applies to the next step only
        run = 1'b1;
        clks(2);
        key_n = 4'b1101;
        do_step();
        chk("samecyc_x", int'(head_x), 90);
        chk("samecyc_dir", int'(dir), 0);
        clks(3);
        do_step();
        chk("nextstep_y", int'(head_y), 40);
        chk("nextstep_dir", int'(dir), 1);
        key_n = 4'hF;

        // Reset between step_req and step_valid
        step_req = 1'b1;
        clks(1);
        step_req = 1'b0;
        reset = 1'b1;
        clks(1);
        reset = 1'b0;
        chk("midrst_x", int'(head_x), 80);
        chk("midrst_y", int'(head_y), 30);
        chk("midrst_sv", int'(step_valid), 0);
        clks(2);
        chk("midrst_sv2", int'(step_valid), 0);

        // Top edge
        set_key(4'b1011);
        repeat (3) do_step();
        chk("top_y", int'(head_y), 0);
        chk("top_dir", int'(dir), 2);
        do_step();
`ifdef SNAKE_WRAP_EN
        chk("top_wrap_y", int'(head_y), 110);
`else
        chk("top_wall_y", int'(head_y), 0);
        chk("top_wall_hit", int'(wall_hit), 1);
`endif
        clks(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
